// File: rtl/focus_stats_fifo_pkg.sv
// focus_stats_fifo_pkg: shared state encoding and entry packing for the focus statistics FIFO
package focus_stats_fifo_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, CLIMB = 2'd1, DESCEND = 2'd2, FOUND = 2'd3} fsm_state_e;
   localparam int POS_MSB = 47;
   localparam int POS_LSB = 32;
   localparam int VAL_MSB = 31;
   localparam int ENTRY_W = POS_MSB + 1;
endpackage

// File: rtl/focus_stats_fifo_if.sv
// focus_stats_fifo_if: sample input, drain port and peak status of the focus statistics FIFO
interface focus_stats_fifo_if #(parameter int DEPTH_LOG2 = 4);
   import focus_stats_fifo_pkg::*;
   logic                  hifreq_stb;
   logic [VAL_MSB:0]      hifreq;
   logic [15:0]           lens_pos;
   logic                  pop;
   logic [ENTRY_W-1:0]    dout;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;
   logic                  overrun;
   logic [VAL_MSB:0]      peak_val;
   logic [15:0]           peak_pos;
   logic                  peak_found;
   logic [1:0]            fsm_state;
   modport master (output hifreq_stb, hifreq, lens_pos, pop,
                   input dout, empty, count, overrun, peak_val, peak_pos, peak_found, fsm_state);
   modport slave  (input hifreq_stb, hifreq, lens_pos, pop,
                   output dout, empty, count, overrun, peak_val, peak_pos, peak_found, fsm_state);
endinterface

// File: rtl/focus_stats_fifo_peak_fsm.sv
// focus_peak_fsm: tracks the sharpness peak of an autofocus sweep and flags when it has been passed
module focus_peak_fsm
   import focus_stats_fifo_pkg::*;
#(
   parameter int THR_SHIFT = 3,
   parameter int DROP_N    = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         push,
   input  logic [31:0]  hifreq,
   input  logic [15:0]  lens_pos,
   output logic [31:0]  peak_val,
   output logic [15:0]  peak_pos,
   output logic         peak_found,
   output fsm_state_e   state
);
   fsm_state_e  state_q, state_d;
   logic [31:0] peak_val_q, peak_val_d;
   logic [15:0] peak_pos_q, peak_pos_d;
   logic [3:0]  drop_cnt_q, drop_cnt_d;
   logic [31:0] thr;
   logic        below, higher;
   assign thr    = peak_val_q - (peak_val_q >> THR_SHIFT);
   assign below  = hifreq < thr;
   assign higher = hifreq > peak_val_q;
   // state, peak and drop counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         peak_val_q <= '0;
         peak_pos_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         peak_val_q <= peak_val_d;
         peak_pos_q <= peak_pos_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end
   // advance only on a push; a within-band sample in DESCEND keeps the drop count
   always_comb begin
      state_d    = state_q;
      peak_val_d = peak_val_q;
      peak_pos_d = peak_pos_q;
      drop_cnt_d = drop_cnt_q;
      if (clear) begin
         state_d    = IDLE;
         peak_val_d = '0;
         peak_pos_d = '0;
         drop_cnt_d = '0;
      end else if (push) begin
         case (state_q)
            IDLE: begin
               peak_val_d = hifreq;
               peak_pos_d = lens_pos;
               state_d    = CLIMB;
            end
            CLIMB: begin
               if (higher) begin
                  peak_val_d = hifreq;
                  peak_pos_d = lens_pos;
               end else if (below) begin
                  drop_cnt_d = 4'd1;
                  state_d    = (DROP_N == 1) ? FOUND : DESCEND;
               end
            end
            DESCEND: begin
               if (higher) begin
                  peak_val_d = hifreq;
                  peak_pos_d = lens_pos;
                  drop_cnt_d = '0;
                  state_d    = CLIMB;
               end else if (below) begin
                  drop_cnt_d = drop_cnt_q + 4'd1;
                  state_d    = (drop_cnt_d == 4'(DROP_N)) ? FOUND : DESCEND;
               end
            end
            default: ;
         endcase
      end
   end
   assign peak_val   = peak_val_q;
   assign peak_pos   = peak_pos_q;
   assign peak_found = state_q == FOUND;
   assign state      = state_q;
endmodule

// File: rtl/focus_stats_fifo.sv
// focus_stats_fifo: show-ahead ring FIFO of per-frame sharpness/lens pairs with peak detection
module focus_stats_fifo
   import focus_stats_fifo_pkg::*;
#(
   parameter int DEPTH_LOG2 = 4,
   parameter int THR_SHIFT  = 3,
   parameter int DROP_N     = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clr,
   focus_stats_fifo_if.slave bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   logic [ENTRY_W-1:0]    mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2:0]   count_q, count_d;
   logic                  overrun_q, overrun_d;
   logic                  clear, push, pop_ok, full, empty;
   fsm_state_e            state;
   assign clear  = !en || clr;
   assign push   = en && bus.hifreq_stb;
   assign empty  = count_q == '0;
   assign full   = count_q == (DEPTH_LOG2 + 1)'(DEPTH);
   assign pop_ok = bus.pop && !empty;
   // a push into a full FIFO without a pop drops the oldest entry by advancing the read pointer
   always_comb begin
      wr_ptr_d  = clear ? '0 : push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d  = clear ? '0 : (pop_ok || (push && full)) ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d   = clear ? '0 : (push && !pop_ok && !full) ? count_q + 1'b1 :
                  (!push && pop_ok) ? count_q - 1'b1 : count_q;
      overrun_d = !clear && (overrun_q || (push && full && !pop_ok));
   end
   // pointer, occupancy and overrun registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         overrun_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         overrun_q <= overrun_d;
      end
   end
   // entry storage, left unreset so it maps onto distributed RAM
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= {bus.lens_pos, bus.hifreq};
   end
   focus_peak_fsm #(.THR_SHIFT(THR_SHIFT), .DROP_N(DROP_N)) u_fsm (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .push       (push),
      .hifreq     (bus.hifreq),
      .lens_pos   (bus.lens_pos),
      .peak_val   (bus.peak_val),
      .peak_pos   (bus.peak_pos),
      .peak_found (bus.peak_found),
      .state      (state)
   );
   assign bus.dout      = empty ? '0 : mem_q[rd_ptr_q];
   assign bus.empty     = empty;
   assign bus.count     = count_q;
   assign bus.overrun   = overrun_q;
   assign bus.fsm_state = state;
endmodule
